// File: rtl/sram_pkg.sv
// Shared types and constants for the clocked SRAM bank controller and its per-bank PHY.
package sram_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD
  } state_e;

  // Level of every active-low strobe pin while no access targets the bank.
  localparam logic STB_IDLE = 1'b1;

  function automatic int bank_bits(input int banks);
    return $clog2(banks);
  endfunction

endpackage

// File: rtl/sram_bank_phy.sv
// One SRAM chip's pin driver: registered strobes, address and write-data bus enable.
module sram_bank_phy
  import sram_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int RAM_ADDR_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel_i,
  input  logic                  en_i,
  input  logic                  oe_i,
  input  logic                  wstb_i,
  input  logic                  drv_i,
  input  logic [RAM_ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  en_n_o,
  output logic                  oe_n_o,
  output logic                  we_n_o,
  output logic [RAM_ADDR_W-1:0] addr_o,
  output logic                  dq_oe_o,
  output logic [DATA_W-1:0]     dq_o
);

  logic                  en_n_q;
  logic                  oe_n_q;
  logic                  we_n_q;
  logic [RAM_ADDR_W-1:0] addr_q;
  logic                  dq_oe_q;
  logic [DATA_W-1:0]     dq_q;

  // Unselected banks see a fully idle command: strobes high, address zero, bus released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_n_q  <= STB_IDLE;
      oe_n_q  <= STB_IDLE;
      we_n_q  <= STB_IDLE;
      addr_q  <= '0;
      dq_oe_q <= 1'b0;
    end else begin
      en_n_q  <= !(sel_i && en_i);
      oe_n_q  <= !(sel_i && oe_i);
      we_n_q  <= !(sel_i && wstb_i);
      addr_q  <= (sel_i && en_i) ? addr_i : '0;
      dq_oe_q <= sel_i && drv_i;
    end
    dq_q <= wdata_i;
  end

  assign en_n_o  = en_n_q;
  assign oe_n_o  = oe_n_q;
  assign we_n_o  = we_n_q;
  assign addr_o  = addr_q;
  assign dq_oe_o = dq_oe_q;
  assign dq_o    = dq_q;

endmodule

// File: rtl/sram_bank_ctrl.sv
// Single-port request controller for BANKS asynchronous SRAM chips with programmable strobe width.
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BANKS       = 2,
  parameter int ADDR_W      = 17,
  parameter int RAM_ADDR_W  = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic                         ready,
  output logic                         done,
  output logic [DATA_W-1:0]            rdata,
  output logic [BANKS-1:0]             ram_en_n,
  output logic [BANKS-1:0]             ram_oe_n,
  output logic [BANKS-1:0]             ram_we_n,
  output logic [BANKS*RAM_ADDR_W-1:0]  ram_addr,
  inout  wire  [BANKS*DATA_W-1:0]      ram_dq
);

  localparam int BB    = bank_bits(BANKS);
  localparam int CA_W  = ADDR_W - BB;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic [BB-1:0]         bank_q;
  logic [RAM_ADDR_W-1:0] caddr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  done_q;
  logic                  ready_q;

  logic [BB-1:0]         req_bank;
  logic [RAM_ADDR_W-1:0] req_caddr;
  logic [DATA_W-1:0]     bank_rd;
  logic                  last_access;

  assign req_bank    = addr[ADDR_W-1 -: BB];
  assign req_caddr   = RAM_ADDR_W'(addr[CA_W-1:0]);
  assign bank_rd     = ram_dq[int'(bank_q)*DATA_W +: DATA_W];
  assign last_access = (cnt_q == CNT_W'(1));

  // Command for the coming cycle; the PHY registers it so pin timing tracks state_q.
  logic                  cmd_en, cmd_oe, cmd_wstb, cmd_drv;
  logic [BB-1:0]         cmd_bank;
  logic [RAM_ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;

  always_comb begin
    cmd_en    = 1'b0;
    cmd_oe    = 1'b0;
    cmd_wstb  = 1'b0;
    cmd_drv   = 1'b0;
    cmd_bank  = bank_q;
    cmd_addr  = caddr_q;
    cmd_wdata = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cmd_en    = 1'b1;
          cmd_oe    = !we;
          cmd_drv   = we;
          cmd_bank  = req_bank;
          cmd_addr  = req_caddr;
          cmd_wdata = wdata;
        end
      end
      S_SETUP: begin
        cmd_en   = 1'b1;
        cmd_oe   = !we_q;
        cmd_wstb = we_q;
        cmd_drv  = we_q;
      end
      S_ACCESS: begin
        cmd_en  = 1'b1;
        cmd_drv = we_q;
        if (!last_access) begin
          cmd_oe   = !we_q;
          cmd_wstb = we_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bank_q  <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q    <= we;
            bank_q  <= req_bank;
            caddr_q <= req_caddr;
            wdata_q <= wdata;
            ready_q <= 1'b0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt_q   <= CNT_W'(WAIT_CYCLES);
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          if (last_access) begin
            state_q <= S_HOLD;
            done_q  <= 1'b1;
            if (!we_q) rdata_q <= bank_rd;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign rdata = rdata_q;

  logic [BANKS-1:0] dq_oe;
  logic [DATA_W-1:0] phy_dq [BANKS];

  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    sram_bank_phy #(
      .DATA_W    (DATA_W),
      .RAM_ADDR_W(RAM_ADDR_W)
    ) u_phy (
      .clk    (clk),
      .rst    (rst),
      .sel_i  (cmd_bank == BB'(i)),
      .en_i   (cmd_en),
      .oe_i   (cmd_oe),
      .wstb_i (cmd_wstb),
      .drv_i  (cmd_drv),
      .addr_i (cmd_addr),
      .wdata_i(cmd_wdata),
      .en_n_o (ram_en_n[i]),
      .oe_n_o (ram_oe_n[i]),
      .we_n_o (ram_we_n[i]),
      .addr_o (ram_addr[i*RAM_ADDR_W +: RAM_ADDR_W]),
      .dq_oe_o(dq_oe[i]),
      .dq_o   (phy_dq[i])
    );
    assign ram_dq[i*DATA_W +: DATA_W] = dq_oe[i] ? phy_dq[i] : {DATA_W{1'bz}};
  end

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl: two-bank SRAM model at W=2, plus a W=4 instance for strobe width.
module tb_sram_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic        ready, done;
  logic [15:0] rdata;
  logic [1:0]  ram_en_n, ram_oe_n, ram_we_n;
  logic [35:0] ram_addr;
  wire  [31:0] ram_dq;

  logic        r2_req, r2_we;
  logic [16:0] r2_addr;
  logic [15:0] r2_wdata;
  logic        r2_ready, r2_done;
  logic [15:0] r2_rdata;
  logic [1:0]  r2_en_n, r2_oe_n, r2_we_n;
  logic [35:0] r2_ram_addr;
  wire  [31:0] r2_ram_dq;

  always #5 clk = ~clk;

  sram_bank_ctrl #(.DATA_W(16), .BANKS(2), .ADDR_W(17), .RAM_ADDR_W(18), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_addr(ram_addr), .ram_dq(ram_dq)
  );

  sram_bank_ctrl #(.DATA_W(16), .BANKS(2), .ADDR_W(17), .RAM_ADDR_W(18), .WAIT_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req(r2_req), .we(r2_we), .addr(r2_addr), .wdata(r2_wdata),
    .ready(r2_ready), .done(r2_done), .rdata(r2_rdata),
    .ram_en_n(r2_en_n), .ram_oe_n(r2_oe_n), .ram_we_n(r2_we_n),
    .ram_addr(r2_ram_addr), .ram_dq(r2_ram_dq)
  );

  // Asynchronous SRAM model, 256 words per chip
  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  assign ram_dq[15:0]  = (!ram_en_n[0] && !ram_oe_n[0]) ? mem0[ram_addr[7:0]]   : 16'hzzzz;
  assign ram_dq[31:16] = (!ram_en_n[1] && !ram_oe_n[1]) ? mem1[ram_addr[25:18]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ram_en_n[0] && !ram_we_n[0]) mem0[ram_addr[7:0]] <= ram_dq[15:0];
    if (!ram_en_n[1] && !ram_we_n[1]) mem1[ram_addr[25:18]] <= ram_dq[31:16];
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          n_en [2], n_oe [2], n_we [2], n_drv [2];
  logic [17:0] addr_seen [2];
  int          n_done, ready_at, bad_dq, stray;
  int          done_at [4];
  logic [15:0] rd_done, wdata_cur;
  logic [1:0]  snap_en, snap_oe, snap_we, snap_drv;
  logic [35:0] snap_addr;
  logic        snap_ready, snap_done;
  logic [15:0] snap_rdata;

  task automatic issue(input logic w, input logic [16:0] a, input logic [15:0] d);
    req = 1'b1; we = w; addr = a; wdata = d; wdata_cur = d;
  endtask

  // Runs ncyc cycles after the request edge; c counts cycles after acceptance.
  task automatic watch(input int ncyc, input int drop_c, input int pulse_c, input int sw_c,
                       input int rst_c);
    for (int b = 0; b < 2; b++) begin
      n_en[b] = 0; n_oe[b] = 0; n_we[b] = 0; n_drv[b] = 0; addr_seen[b] = '0;
    end
    n_done = 0; ready_at = -1; bad_dq = 0; stray = 0; rd_done = '0;
    for (int k = 0; k < 4; k++) done_at[k] = -1;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      for (int b = 0; b < 2; b++) begin
        if (!ram_en_n[b]) begin
          n_en[b]++;
          addr_seen[b] = ram_addr[b*18 +: 18];
        end else if (ram_addr[b*18 +: 18] != 18'd0 || !ram_oe_n[b] || !ram_we_n[b]) begin
          stray++;
        end
        if (!ram_oe_n[b]) n_oe[b]++;
        if (!ram_we_n[b]) n_we[b]++;
        if (dut.dq_oe[b]) begin
          n_drv[b]++;
          if (ram_dq[b*16 +: 16] !== wdata_cur) bad_dq++;
        end
      end
      if (done) begin
        if (n_done < 4) done_at[n_done] = c;
        n_done++;
        rd_done = rdata;
      end
      if (ready && ready_at < 0) ready_at = c;
      if (rst_c > 0 && c == rst_c + 1) begin
        snap_en = ram_en_n; snap_oe = ram_oe_n; snap_we = ram_we_n; snap_drv = dut.dq_oe;
        snap_addr = ram_addr; snap_ready = ready; snap_done = done; snap_rdata = rdata;
        rst = 1'b1;
      end
      if (c == drop_c) req = 1'b0;
      if (pulse_c > 0 && c == pulse_c) begin
        req = 1'b1; addr = addr ^ 17'h10000;
      end
      if (pulse_c > 0 && c == pulse_c + 1) req = 1'b0;
      if (c == sw_c) we = 1'b0;
      if (rst_c > 0 && c == rst_c) rst = 1'b0;
    end
  endtask

  int w4_we, w4_done_at;
  logic [15:0] w4_dq;

  initial begin
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wdata_cur = '0;
    r2_req = 1'b0; r2_we = 1'b0; r2_addr = '0; r2_wdata = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_strobes", {26'd0, ram_en_n, ram_oe_n, ram_we_n}, 32'h3f);
    chk("rst_addr", {31'd0, |ram_addr}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_drv", {30'd0, dut.dq_oe}, 32'd0);

    // Write 0x000E to bank 0, word 5
    issue(1'b1, 17'h00005, 16'h000E);
    watch(6, 1, 0, 0, 0);
    chk("wr0_we_lo", n_we[0], 2);
    chk("wr0_en_lo", n_en[0], 4);
    chk("wr0_drv", n_drv[0], 4);
    chk("wr0_dq", bad_dq, 0);
    chk("wr0_addr", {14'd0, addr_seen[0]}, 32'h5);
    chk("wr0_done_at", done_at[0], 4);
    chk("wr0_ndone", n_done, 1);
    chk("wr0_ready_at", ready_at, 5);
    chk("wr0_bank1", n_en[1] + n_drv[1], 0);
    chk("wr0_stray", stray, 0);
    chk("wr0_mem", {16'd0, mem0[5]}, 32'h000E);

    // Read it back
    issue(1'b0, 17'h00005, 16'hFFFF);
    watch(6, 1, 0, 0, 0);
    chk("rd0_oe_lo", n_oe[0], 3);
    chk("rd0_we_lo", n_we[0], 0);
    chk("rd0_drv", n_drv[0] + n_drv[1], 0);
    chk("rd0_done_at", done_at[0], 4);
    chk("rd0_rdata", {16'd0, rd_done}, 32'h000E);

    // Bank 1 write then read
    issue(1'b1, 17'h10005, 16'h1234);
    watch(6, 1, 0, 0, 0);
    chk("wr1_we_lo", n_we[1], 2);
    chk("wr1_bank0", n_en[0], 0);
    chk("wr1_addr", {14'd0, addr_seen[1]}, 32'h5);
    chk("wr1_mem", {16'd0, mem1[5]}, 32'h1234);
    issue(1'b0, 17'h10005, 16'h0000);
    watch(6, 1, 0, 0, 0);
    chk("rd1_rdata", {16'd0, rd_done}, 32'h1234);
    chk("rd1_bank0_mem", {16'd0, mem0[5]}, 32'h000E);
    chk("rd1_stray", stray, 0);

    // Back-to-back: write then read, req held through the ready cycle
    issue(1'b1, 17'h10007, 16'hBEEF);
    watch(11, 6, 0, 4, 0);
    chk("b2b_ndone", n_done, 2);
    chk("b2b_done0", done_at[0], 4);
    chk("b2b_done1", done_at[1], 9);
    chk("b2b_rdata", {16'd0, rd_done}, 32'hBEEF);
    chk("b2b_oe_lo", n_oe[1], 3);
    chk("b2b_drv", n_drv[1], 4);

    // req pulse during ACCESS must be ignored
    issue(1'b1, 17'h00020, 16'h0F0F);
    watch(10, 1, 2, 0, 0);
    chk("pulse_ndone", n_done, 1);
    chk("pulse_en0", n_en[0], 4);
    chk("pulse_bank1", n_en[1], 0);

    // Reset during ACCESS of a write
    issue(1'b1, 17'h00009, 16'h5555);
    watch(6, 1, 0, 0, 2);
    chk("arst_strobes", {26'd0, snap_en, snap_oe, snap_we}, 32'h3f);
    chk("arst_addr", {31'd0, |snap_addr}, 32'd0);
    chk("arst_drv", {30'd0, snap_drv}, 32'd0);
    chk("arst_ready", {31'd0, snap_ready}, 32'd1);
    chk("arst_done", {31'd0, snap_done}, 32'd0);
    chk("arst_rdata", {16'd0, snap_rdata}, 32'd0);
    chk("arst_ndone", n_done, 0);

    // W=4 instance: strobe width and done latency
    r2_req = 1'b1; r2_we = 1'b1; r2_addr = 17'h00003; r2_wdata = 16'hA5A5;
    w4_we = 0; w4_done_at = -1; w4_dq = '0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        r2_req = 1'b0;
        w4_dq = r2_ram_dq[15:0];
      end
      if (!r2_we_n[0]) w4_we++;
      if (r2_done && w4_done_at < 0) w4_done_at = c;
    end
    chk("w4_we_lo", w4_we, 4);
    chk("w4_done_at", w4_done_at, 6);
    chk("w4_dq", {16'd0, w4_dq}, 32'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
